// File: rtl/rv_pkg.sv
// Shared RV32 definitions: ALU operation codes, R-type opcode and the
// execute-sequencer state encoding, plus the funct3/funct7 -> ALU code map.
package rv_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    typedef enum logic [2:0] {
        IDLE,
        RD_RS1,
        RD_RS2,
        LAT_RS2,
        EXEC,
        WB
    } seq_state_e;

    // Only funct7 == 0x20 selects the alternate op; legality is checked elsewhere.
    function automatic logic [4:0] alu_code(input logic [2:0] funct3, input logic [6:0] funct7);
        logic [4:0] code;
        code = ALU_ADD;
        unique case (funct3)
            3'b000: code = (funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
            3'b001: code = ALU_SLL;
            3'b010: code = ALU_SLT;
            3'b011: code = ALU_SLTU;
            3'b100: code = ALU_XOR;
            3'b101: code = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            3'b110: code = ALU_OR;
            3'b111: code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rtype_exec_sequencer_if.sv
// Instruction handshake, shared regfile port and ALU port of the R-type sequencer.
// slave = sequencer side, master = fetch/datapath side.
interface rtype_exec_sequencer_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            busy;
    logic            done;
    logic            illegal;

    modport slave (
        input  instr_valid, instr, rf_rdata, alu_result,
        output instr_ready, rf_raddr, alu_a, alu_b, alu_ctrl,
               rf_we, rf_waddr, rf_wdata, busy, done, illegal
    );

    modport master (
        output instr_valid, instr, rf_rdata, alu_result,
        input  instr_ready, rf_raddr, alu_a, alu_b, alu_ctrl,
               rf_we, rf_waddr, rf_wdata, busy, done, illegal
    );
endinterface

// File: rtl/rtype_exec_sequencer_decode.sv
// R-type field extraction: raw fields combinationally for the legality check,
// plus registers holding rd/rs1/rs2 and the ALU code of the accepted word.
module rtype_exec_sequencer_decode
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rd_q_o,
    output logic [4:0]  rs1_q_o,
    output logic [4:0]  rs2_q_o,
    output logic [4:0]  alu_ctrl_q_o
);
    logic [4:0] rd_q, rs1_q, rs2_q, alu_ctrl_q;
    logic [4:0] alu_ctrl_d;

    assign opcode_o   = instr_i[6:0];
    assign funct3_o   = instr_i[14:12];
    assign funct7_o   = instr_i[31:25];
    assign rs1_o      = instr_i[19:15];
    assign alu_ctrl_d = alu_code(instr_i[14:12], instr_i[31:25]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_ctrl_q <= ALU_ADD;
        end else if (load_i) begin
            rd_q       <= instr_i[11:7];
            rs1_q      <= instr_i[19:15];
            rs2_q      <= instr_i[24:20];
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    assign rd_q_o       = rd_q;
    assign rs1_q_o      = rs1_q;
    assign rs2_q_o      = rs2_q;
    assign alu_ctrl_q_o = alu_ctrl_q;
endmodule

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle RV32 R-type executor: accept, read rs1/rs2 over one sync regfile
// port, drive the ALU, write back rd. Accept-to-writeback is 5 cycles.
module rtype_exec_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rtype_exec_sequencer_if.slave bus
);
    import rv_pkg::*;

    seq_state_e      state_q;
    logic [4:0]      raddr_q;
    logic [XLEN-1:0] opa_q, opb_q, result_q;
    logic            we_q, done_q, illegal_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1_raw, rd_q, rs1_q, rs2_q, alu_ctrl_q;
    logic       accept, legal;

    assign accept = bus.instr_valid && bus.instr_ready;

    rtype_exec_sequencer_decode decode_reg_inst (
        .clk          (clk),
        .rst          (rst),
        .load_i       (accept),
        .instr_i      (bus.instr),
        .opcode_o     (opcode),
        .funct3_o     (funct3),
        .funct7_o     (funct7),
        .rs1_o        (rs1_raw),
        .rd_q_o       (rd_q),
        .rs1_q_o      (rs1_q),
        .rs2_q_o      (rs2_q),
        .alu_ctrl_q_o (alu_ctrl_q)
    );

    // funct7 = 0x20 is only meaningful for SUB and SRA.
    always_comb begin
        legal = 1'b0;
        if (opcode == OPC_RTYPE) begin
            if (funct7 == 7'h00)
                legal = 1'b1;
            else if (funct7 == 7'h20)
                legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            state_q <= RD_RS1;
                            raddr_q <= rs1_raw;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                RD_RS1: begin
                    state_q <= RD_RS2;
                    raddr_q <= rs2_q;
                end
                // Read data arrives one cycle after its address; x0 never reads the array.
                RD_RS2: begin
                    state_q <= LAT_RS2;
                    opa_q   <= (rs1_q == 5'd0) ? '0 : bus.rf_rdata;
                end
                LAT_RS2: begin
                    state_q <= EXEC;
                    opb_q   <= (rs2_q == 5'd0) ? '0 : bus.rf_rdata;
                end
                EXEC: begin
                    state_q  <= WB;
                    result_q <= bus.alu_result;
                    we_q     <= (rd_q != 5'd0);
                    done_q   <= 1'b1;
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE) && !rst;
    assign bus.busy        = (state_q != IDLE);
    assign bus.rf_raddr    = raddr_q;
    assign bus.alu_a       = opa_q;
    assign bus.alu_b       = opb_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_waddr    = rd_q;
    assign bus.rf_wdata    = result_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Bench for rtype_exec_sequencer: behavioural regfile/ALU around the DUT and an
// instruction-level reference model of RV32 R-type semantics.
module tb_rtype_exec_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtype_exec_sequencer_if bus ();

    rtype_exec_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] ref_rf [32];
    logic [4:0]  prev_raddr;

    logic        bd_we = 1'b0;
    logic [4:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    // Synchronous-read regfile; the backdoor port preloads it while the DUT is idle.
    always @(posedge clk) begin
        bus.rf_rdata <= rf_mem[bus.rf_raddr];
        if (bd_we)
            rf_mem[bd_addr] <= bd_data;
        else if (bus.rf_we)
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end

    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_ctrl)
            5'd0: bus.alu_result = bus.alu_a + bus.alu_b;
            5'd1: bus.alu_result = bus.alu_a - bus.alu_b;
            5'd2: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            5'd3: bus.alu_result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            5'd4: bus.alu_result = {31'b0, bus.alu_a < bus.alu_b};
            5'd5: bus.alu_result = bus.alu_a ^ bus.alu_b;
            5'd6: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            5'd7: bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            5'd8: bus.alu_result = bus.alu_a | bus.alu_b;
            5'd9: bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic bit ref_legal(input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        if (ins[6:0] != 7'b0110011) return 1'b0;
        if (f7 == 7'h00) return 1'b1;
        return (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit alt;
        alt = (ins[31:25] == 7'h20);
        case (ins[14:12])
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [4:0] ref_code(input logic [31:0] ins);
        logic [4:0] tbl [8];
        tbl = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        if (ins[31:25] == 7'h20) return (ins[14:12] == 3'd0) ? 5'd1 : 5'd7;
        return tbl[ins[14:12]];
    endfunction

    task automatic ref_apply(input logic [31:0] ins);
        if (ins[11:7] != 5'd0)
            ref_rf[ins[11:7]] = ref_result(ins, ref_rf[ins[19:15]], ref_rf[ins[24:20]]);
    endtask

    task automatic poke(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        ref_rf[addr] = (addr == 5'd0) ? 32'd0 : data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic exec_one(input logic [31:0] ins);
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b;
        bit          ok;
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        ok  = ref_legal(ins);
        a   = ref_rf[rs1];
        b   = ref_rf[rs2];
        @(negedge clk);
        chk("ready_idle", {31'b0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        if (!ok) begin
            chk("illegal_pulse", {31'b0, bus.illegal}, 32'd1);
            chk("illegal_busy", {31'b0, bus.busy}, 32'd0);
            chk("illegal_ready", {31'b0, bus.instr_ready}, 32'd1);
            chk("illegal_raddr", {27'b0, bus.rf_raddr}, {27'b0, prev_raddr});
            @(negedge clk);
            chk("illegal_clear", {31'b0, bus.illegal}, 32'd0);
            chk("illegal_nowe", {31'b0, bus.rf_we}, 32'd0);
            return;
        end
        chk("t1_raddr", {27'b0, bus.rf_raddr}, {27'b0, rs1});
        chk("t1_busy", {31'b0, bus.busy}, 32'd1);
        chk("t1_ready", {31'b0, bus.instr_ready}, 32'd0);
        chk("t1_illegal", {31'b0, bus.illegal}, 32'd0);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k < 5) chk("pre_wb_we", {31'b0, bus.rf_we}, 32'd0);
            if (k == 2) chk("t2_raddr", {27'b0, bus.rf_raddr}, {27'b0, rs2});
            if (k == 4) begin
                chk("exec_a", bus.alu_a, a);
                chk("exec_b", bus.alu_b, b);
                chk("exec_ctrl", {27'b0, bus.alu_ctrl}, {27'b0, ref_code(ins)});
            end
            if (k == 5) begin
                chk("wb_we", {31'b0, bus.rf_we}, {31'b0, rd != 5'd0});
                chk("wb_done", {31'b0, bus.done}, 32'd1);
                if (rd != 5'd0) begin
                    chk("wb_waddr", {27'b0, bus.rf_waddr}, {27'b0, rd});
                    chk("wb_wdata", bus.rf_wdata, ref_result(ins, a, b));
                end
            end
            if (k == 6) begin
                chk("t6_busy", {31'b0, bus.busy}, 32'd0);
                chk("t6_done", {31'b0, bus.done}, 32'd0);
                chk("t6_we", {31'b0, bus.rf_we}, 32'd0);
            end
        end
        ref_apply(ins);
        prev_raddr = rs2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins_a, ins_b, ins;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        prev_raddr      = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_we", {31'b0, bus.rf_we}, 32'd0);
        chk("rst_ctrl", {27'b0, bus.alu_ctrl}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, bus.instr_ready}, 32'd1);

        for (int i = 0; i < 32; i++) poke(5'(i), $urandom);

        poke(5'd1, 32'd5);
        poke(5'd2, 32'd7);
        exec_one(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011));
        chk("add_x3", ref_rf[3], 32'd12);
        exec_one(mk(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011));
        chk("sub_x4", ref_rf[4], 32'hFFFF_FFFE);
        poke(5'd1, 32'h8000_0000);
        poke(5'd2, 32'd4);
        exec_one(mk(7'h20, 5'd2, 5'd1, 3'd5, 5'd5, 7'b0110011));
        chk("sra_x5", ref_rf[5], 32'hF800_0000);
        exec_one(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011));
        exec_one(mk(7'h00, 5'd0, 5'd2, 3'd0, 5'd9, 7'b0110011));
        exec_one(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010011));
        exec_one(mk(7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'b0110011));

        // Reset while the instruction sits in EXEC.
        poke(5'd6, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_we", {31'b0, bus.rf_we}, 32'd0);
        chk("arst_ctrl", {27'b0, bus.alu_ctrl}, 32'd0);
        chk("arst_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ready", {31'b0, bus.instr_ready}, 32'd1);
        prev_raddr = '0;
        repeat (8) @(negedge clk);
        chk("arst_nowrite", rf_mem[6], ref_rf[6]);
        exec_one(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011));

        // Valid held high across two different words.
        ins_a = mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011);
        ins_b = mk(7'h00, 5'd4, 5'd3, 3'd4, 5'd8, 7'b0110011);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins_a;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.instr = ins_b;
            chk("b2b_ready_low", {31'b0, bus.instr_ready}, 32'd0);
            if (k == 5) chk("b2b_done_a", {31'b0, bus.done}, 32'd1);
        end
        ref_apply(ins_a);
        @(negedge clk);
        chk("b2b_ready_t6", {31'b0, bus.instr_ready}, 32'd1);
        chk("b2b_idle_t6", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("b2b_accept_b", {31'b0, bus.busy}, 32'd1);
        chk("b2b_raddr_b", {27'b0, bus.rf_raddr}, 32'd3);
        repeat (5) @(negedge clk);
        ref_apply(ins_b);
        prev_raddr = 5'd4;

        for (int n = 0; n < 60; n++) begin
            logic [6:0] f7, opc;
            f7  = ($urandom_range(0, 9) < 5) ? 7'h00 : (($urandom_range(0, 4) != 0) ? 7'h20 : 7'($urandom));
            opc = ($urandom_range(0, 9) != 0) ? 7'b0110011 : 7'($urandom);
            ins = mk(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc);
            exec_one(ins);
        end

        @(negedge clk);
        for (int i = 1; i < 32; i++) chk("final_rf", rf_mem[i], ref_rf[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
